range_xor_reg8: RTL and testbench
=================================

Name: range_xor_reg8

Overview:
- 8-entry, 1-bit-per-entry XOR accumulator register file with a prefix-XOR read port.
- Built from three leaf blocks: a single-bit D flip-flop (DFF), a one-hot write-index decoder (INDECODER8) and a thermometer read-index decoder (OUTDECODER8).
- Used as the storage/query core of the bitxor datapath: point updates XOR a bit into one cell; a query returns the XOR of cells 0..idx.

Parameters:
None (depth fixed at 8, index width 3, data width 1).

Ports:
- clk  input  1  rising-edge clock for all cells.
- reset  input  1  asynchronous, active-high; clears all cells.
- inst  input  2  operation code. 2'b00 = update; any non-zero value = query mode.
- idx  input  3  cell index; the write target in update mode and the prefix end in all modes.
- xorval  input  1  bit XORed into the write-target cell on each rising clk edge.
- rangexor  output  1  combinational XOR of cells 0..idx.

Behaviour:
Clock and reset
- Exactly one clock (clk) and one reset (reset); reset is asynchronous and active-high.
- DFF: q updates to d on the clk rising edge. While reset=1, q=0 immediately, independent of clk.
- Reset value of all 8 cells is 0, so rangexor=0 for any idx while in reset and after reset release.

Write path (INDECODER8, one-hot)
- Write index wi: wi[b] = idx[b] | inst[0] | inst[1] for each bit b. This gives wi=idx when inst=00 and wi=7 otherwise.
- in_use[j] = (j == wi); exactly one bit is set.
- Cell j next state = q[j] ^ (xorval & in_use[j]), sampled on the clk rising edge. No cell changes when xorval=0.
- In query mode the write target is forced to cell 7. Therefore xorval=1 with inst!=00 toggles cell 7; callers must drive xorval=0 for a side-effect-free query.

Read path (OUTDECODER8, thermometer)
- out_use[j] = (j <= idx). Example: idx=0 -> 8'b0000_0001; idx=7 -> 8'hFF.
- rangexor = XOR over j of (q[j] & out_use[j]). The output is purely combinational from idx and the cell state, with no register stage.

Timing
- After an update at edge N, the new value is visible on rangexor immediately after edge N (zero cycles of read latency beyond the write edge).
- Inputs are sampled only at the rising edge. Benches change inputs away from the edge, e.g. on the falling edge.

Boundary conditions
- Updating the same cell twice with xorval=1 restores its original value.
- idx=7 queries the parity of all 8 cells.
- Reset asserted between edges clears state at once; the next edge after release performs a normal update.
- Reset and a clk edge together: reset wins and all cells stay 0.

Test Plan:
- Reset 1 then 0, xorval=0, sweep idx 0..7 with inst=01 -> rangexor=0 for every idx.
- inst=00, idx=3, xorval=1, one edge. Then inst=01, xorval=0: idx=2 -> 0, idx=3 -> 1, idx=7 -> 1.
- Additionally update idx=5 with xorval=1. Then idx=4 -> 1, idx=5 -> 0, idx=7 -> 0. Update idx=3 again -> idx=7 -> 1 (cell 3 cancelled, cell 5 remains).
- inst=10, idx=0, xorval=1, one edge -> cell 7 toggles: idx=6 unchanged, idx=7 flips.
- Set cells 0, 1 and 6, then pulse reset between edges, away from clk -> rangexor=0 immediately for idx=7 and all other idx. A subsequent update at idx=1 -> idx=1 reads 1.
- Random sequence of 200 ops compared against a reference 8-bit array model: update = toggle bit wi when xorval=1; query = parity of bits 0..idx.

Source files
------------

// File: rtl/range_xor_reg8.sv
// range_xor_reg8: eight 1-bit XOR accumulator cells with a prefix-XOR read port.
// A point update XORs xorval into one cell. The read port returns the XOR of
// cells 0..idx.
//
// Ports:
//   clk      - rising-edge clock for all cells
//   reset    - asynchronous, active-high; clears every cell
//   inst     - 2'b00 = update cell idx; any non-zero value = query mode
//              (in query mode the write target is forced to cell 7)
//   idx      - write target in update mode, prefix end in all modes
//   xorval   - bit XORed into the write-target cell on each rising clk edge
//   rangexor - combinational XOR of cells 0..idx

// Single-bit storage cell with asynchronous clear.
module range_xor_dff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  // Capture d on the rising edge; reset clears the cell at once, whatever clk is doing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= 1'b0;
    else
      q <= d;
  end

endmodule

// One-hot write decoder. Any non-zero inst forces every index bit high, so
// query mode always targets cell 7. Callers must hold xorval=0 for a query
// that leaves the cells unchanged.
module range_xor_indecoder8 (
  input  logic [1:0] inst,
  input  logic [2:0] idx,
  output logic [7:0] in_use
);

  logic [2:0] wi;

  always_comb begin
    wi     = idx | {3{inst[0] | inst[1]}};
    in_use = 8'b0000_0001 << wi;
  end

endmodule

// Thermometer read decoder: bit j is set for every cell at or below idx.
module range_xor_outdecoder8 (
  input  logic [2:0] idx,
  output logic [7:0] out_use
);

  always_comb begin
    out_use = '0;
    for (int j = 0; j < 8; j++)
      out_use[j] = (j <= int'(idx));
  end

endmodule

// Top level: decoders plus eight cells.
module range_xor_reg8 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] inst,
  input  logic [2:0] idx,
  input  logic       xorval,
  output logic       rangexor
);

  logic [7:0] q;
  logic [7:0] d;
  logic [7:0] in_use;
  logic [7:0] out_use;

  range_xor_indecoder8 u_indec (
    .inst   (inst),
    .idx    (idx),
    .in_use (in_use)
  );

  range_xor_outdecoder8 u_outdec (
    .idx     (idx),
    .out_use (out_use)
  );

  // Only the selected cell can flip, and only when xorval is 1.
  always_comb begin
    d = q ^ ({8{xorval}} & in_use);
  end

  for (genvar j = 0; j < 8; j++) begin : g_cell
    range_xor_dff u_cell (
      .clk   (clk),
      .reset (reset),
      .d     (d[j]),
      .q     (q[j])
    );
  end

  // The read is purely combinational, so a write is visible right after its edge.
  always_comb begin
    rangexor = ^(q & out_use);
  end

endmodule

// File: tb/tb_range_xor_reg8.sv
// Testbench for range_xor_reg8. Directed scenarios with hand-computed
// expectations, followed by a random sequence checked against an 8-bit model.
// Inputs change on the falling edge of clk, and outputs are sampled 1ns after that.
module tb_range_xor_reg8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] inst = 2'b01;
  logic [2:0] idx = 3'd0;
  logic       xorval = 1'b0;
  logic       rangexor;

  int n_checks = 0;
  int n_fail = 0;

  range_xor_reg8 dut (
    .clk      (clk),
    .reset    (reset),
    .inst     (inst),
    .idx      (idx),
    .xorval   (xorval),
    .rangexor (rangexor)
  );

  always #5 clk = ~clk;

  // Present an operation on the falling edge. The next rising edge applies it.
  task automatic drive(input logic [1:0] i, input logic [2:0] x, input logic v);
    @(negedge clk);
    inst = i;
    idx = x;
    xorval = v;
  endtask

  // Move to a side-effect-free query of idx x, then let the output settle.
  task automatic set_query(input logic [2:0] x);
    @(negedge clk);
    inst = 2'b01;
    idx = x;
    xorval = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    inst = 2'b01;
    idx = 3'd7;
    xorval = 1'b0;
    #1;
    n_checks++;
    if (rangexor !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_held idx=7 got=%b exp=0", rangexor);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      set_query(3'(k));
      n_checks++;
      if (rangexor !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_sweep idx=%0d got=%b exp=0", k, rangexor);
      end
    end
  endtask

  task automatic test_update();
    logic [2:0] qi [7];
    logic       qe [7];
    qi = '{3'd2, 3'd3, 3'd7, 3'd4, 3'd5, 3'd7, 3'd7};
    qe = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    drive(2'b00, 3'd3, 1'b1);
    for (int k = 0; k < 7; k++) begin
      if (k == 3) drive(2'b00, 3'd5, 1'b1);
      if (k == 6) drive(2'b00, 3'd3, 1'b1);
      set_query(qi[k]);
      n_checks++;
      if (rangexor !== qe[k]) begin
        n_fail++;
        $display("[TB] FAIL update step=%0d idx=%0d got=%b exp=%b", k, qi[k], rangexor, qe[k]);
      end
    end
  endtask

  // Only cell 5 is set at this point. A query-mode write must toggle cell 7.
  task automatic test_query_write();
    drive(2'b10, 3'd0, 1'b1);
    set_query(3'd6);
    n_checks++;
    if (rangexor !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL query_write idx=6 got=%b exp=1", rangexor);
    end
    set_query(3'd7);
    n_checks++;
    if (rangexor !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL query_write idx=7 got=%b exp=0", rangexor);
    end
  endtask

  task automatic test_async_reset();
    drive(2'b00, 3'd0, 1'b1);
    drive(2'b00, 3'd1, 1'b1);
    drive(2'b00, 3'd6, 1'b1);
    // The cells now hold 0, 1, 5, 6 and 7, so the parity of all eight is 1.
    set_query(3'd7);
    n_checks++;
    if (rangexor !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL pre_reset idx=7 got=%b exp=1", rangexor);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (rangexor !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL async_reset idx=7 got=%b exp=0", rangexor);
    end
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      set_query(3'(k));
      n_checks++;
      if (rangexor !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL post_reset idx=%0d got=%b exp=0", k, rangexor);
      end
    end
    drive(2'b00, 3'd1, 1'b1);
    set_query(3'd1);
    n_checks++;
    if (rangexor !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL after_reset_update idx=1 got=%b exp=1", rangexor);
    end
    set_query(3'd0);
    n_checks++;
    if (rangexor !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL after_reset_update idx=0 got=%b exp=0", rangexor);
    end
  endtask

  // Reset stays high across a rising edge that carries an update, and reset must win.
  task automatic test_reset_with_edge();
    drive(2'b00, 3'd2, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (rangexor !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_edge idx=2 got=%b exp=0", rangexor);
    end
    @(negedge clk);
    xorval = 1'b0;
    reset = 1'b0;
    set_query(3'd7);
    n_checks++;
    if (rangexor !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_edge idx=7 got=%b exp=0", rangexor);
    end
  endtask

  // Two updates of the same cell on consecutive edges cancel each other.
  task automatic test_back_to_back();
    drive(2'b00, 3'd4, 1'b1);
    @(negedge clk);
    #1;
    n_checks++;
    if (rangexor !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL back_to_back first idx=4 got=%b exp=1", rangexor);
    end
    @(negedge clk);
    xorval = 1'b0;
    #1;
    n_checks++;
    if (rangexor !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL back_to_back second idx=4 got=%b exp=0", rangexor);
    end
  endtask

  task automatic test_random();
    logic [7:0] m;
    logic [1:0] ri;
    logic [2:0] rx;
    logic [2:0] wi;
    logic       rv;
    logic       exp;
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    m = 8'h00;
    for (int n = 0; n < 200; n++) begin
      ri = 2'($urandom_range(0, 3));
      rx = 3'($urandom_range(0, 7));
      rv = 1'($urandom_range(0, 1));
      drive(ri, rx, rv);
      #1;
      exp = 1'b0;
      for (int j = 0; j <= int'(rx); j++) exp = exp ^ m[j];
      n_checks++;
      if (rangexor !== exp) begin
        n_fail++;
        $display("[TB] FAIL random op=%0d inst=%0d idx=%0d got=%b exp=%b model=%b",
                 n, ri, rx, rangexor, exp, m);
      end
      wi = (ri != 2'b00) ? 3'd7 : rx;
      if (rv) m[wi] = ~m[wi];
    end
    set_query(3'd7);
    n_checks++;
    if (rangexor !== ^m) begin
      n_fail++;
      $display("[TB] FAIL random_final idx=7 got=%b exp=%b", rangexor, ^m);
    end
  endtask

  initial begin
    test_reset();
    test_update();
    test_query_write();
    test_async_reset();
    test_reset_with_edge();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
